// File: rtl/spad_ctrl_pkg.sv
// Shared types and constants for the single-port scratchpad port controller.
package spad_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int unsigned RD_FIFO_DEPTH = 2;
  localparam int unsigned RD_CNT_W      = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/spad_rd_fifo.sv
// Small register FIFO that absorbs SPad read data so clients never see RAM latency.
module spad_rd_fifo
  import spad_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [RD_CNT_W-1:0]   count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + RD_CNT_W'(push) - RD_CNT_W'(pop);
    end
  end

  // Data storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/spad_sp_port_ctrl.sv
// Burst controller for a single-port scratchpad: sequences addresses, arbitrates
// re/we and buffers read data behind a valid/ready stream.
module spad_sp_port_ctrl
  import spad_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  spad_re_o,
  output logic                  spad_we_o,
  output logic [ADDR_WIDTH-1:0] spad_addr_o,
  output logic [DATA_WIDTH-1:0] spad_data_o,
  input  logic [DATA_WIDTH-1:0] spad_data_i
);

  localparam int unsigned OCC_W = RD_CNT_W + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] beats_left;
  logic                  inflight;
  logic                  pop;
  logic                  step;
  logic [RD_CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]      occupancy;
  logic [DATA_WIDTH-1:0] fifo_head;

  // Words that will still be held after this cycle's pop; issue only if one slot stays free.
  assign pop       = rdata_valid_o && rdata_ready_i;
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);

  assign cmd_ready_o   = (state == IDLE);
  assign wdata_ready_o = (state == WRITE);
  assign spad_we_o     = (state == WRITE) && wdata_valid_i;
  assign spad_re_o     = (state == READ) && (occupancy < OCC_W'(RD_FIFO_DEPTH));
  assign spad_addr_o   = cur_addr;
  assign spad_data_o   = wdata_i;
  assign rdata_valid_o = (fifo_count != '0);
  assign rdata_o       = fifo_head;
  assign busy_o        = (state != IDLE) || inflight || rdata_valid_o;
  assign step          = spad_we_o || spad_re_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= spad_re_o;
      if (state == IDLE) begin
        if (cmd_valid_i) begin
          cur_addr   <= cmd_addr_i;
          beats_left <= cmd_len_i;
          state      <= cmd_we_i ? WRITE : READ;
        end
      end else if (step) begin
        cur_addr   <= cur_addr + ADDR_WIDTH'(1);
        beats_left <= beats_left - ADDR_WIDTH'(1);
        if (beats_left == '0) state <= IDLE;
      end
    end
  end

  spad_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (inflight),
    .push_data(spad_data_i),
    .pop      (pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_spad_sp_port_ctrl.sv
// Self-checking bench for spad_sp_port_ctrl: SPad model, burst-level reference
// model, directed scenarios and a randomized command phase.
module tb_spad_sp_port_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wbeat_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [AW-1:0] cmd_len_i = '0;
  logic          wdata_valid_i = 1'b0;
  logic          wdata_ready_o;
  logic [DW-1:0] wdata_i = '0;
  logic          rdata_valid_o;
  logic          rdata_ready_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic          busy_o;
  logic          spad_re_o;
  logic          spad_we_o;
  logic [AW-1:0] spad_addr_o;
  logic [DW-1:0] spad_data_o;
  logic [DW-1:0] spad_data_i;

  spad_sp_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o),
    .wdata_i      (wdata_i),
    .rdata_valid_o(rdata_valid_o),
    .rdata_ready_i(rdata_ready_i),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .spad_re_o    (spad_re_o),
    .spad_we_o    (spad_we_o),
    .spad_addr_o  (spad_addr_o),
    .spad_data_o  (spad_data_o),
    .spad_data_i  (spad_data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached single-port RAM with 1-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (spad_we_o) ram[spad_addr_o] <= spad_data_o;
    if (spad_re_o) ram_q <= ram[spad_addr_o];
  end
  assign spad_data_i = ram_q;

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  wbeat_t        exp_wq[$];
  logic [DW-1:0] exp_rdq[$];
  int            re_cyc[$];
  int            rd_left = 0;
  int            wr_left = 0;
  logic [AW-1:0] exp_raddr = '0;

  int            we_log_cyc[$];
  logic [AW-1:0] we_log_addr[$];
  int            re_log[$];
  int            rd_log_cyc[$];
  logic [DW-1:0] rd_log_data[$];

  int checks = 0;
  int errors = 0;

  int rdy_mode = 0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rdata_ready_i = 1'b0;
      1:       rdata_ready_i = 1'b1;
      default: rdata_ready_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the burst-level model.
  logic   c_exp_valid;
  logic   c_pop;
  logic   c_exp_re;
  wbeat_t c_wb;
  always @(negedge clk) begin
    if (rst_ni) begin
      c_exp_valid = (re_cyc.size() > 0) ? (cyc >= re_cyc[0] + 2) : 1'b0;
      c_pop       = c_exp_valid && rdata_ready_i;
      c_exp_re    = (rd_left > 0) && ((re_cyc.size() - (c_pop ? 1 : 0)) < 2);
      chk("rdata_valid", 32'(rdata_valid_o), 32'(c_exp_valid));
      chk("busy", 32'(busy_o), 32'((rd_left > 0) || (wr_left > 0) || (re_cyc.size() > 0)));
      chk("cmd_ready", 32'(cmd_ready_o), 32'((rd_left == 0) && (wr_left == 0)));
      chk("wdata_ready", 32'(wdata_ready_o), 32'(wr_left > 0));
      chk("we", 32'(spad_we_o), 32'((wr_left > 0) && wdata_valid_i));
      chk("re", 32'(spad_re_o), 32'(c_exp_re));
      if (spad_we_o) begin
        chk("we_pending", 32'(exp_wq.size() > 0), 32'(1));
        if (exp_wq.size() > 0) begin
          c_wb = exp_wq.pop_front();
          chk("we_addr", 32'(spad_addr_o), 32'(c_wb.addr));
          chk("we_data", 32'(spad_data_o), 32'(c_wb.data));
        end
        we_log_cyc.push_back(cyc);
        we_log_addr.push_back(spad_addr_o);
        if (wr_left > 0) wr_left--;
      end
      if (spad_re_o) begin
        chk("re_addr", 32'(spad_addr_o), 32'(exp_raddr));
        exp_raddr = exp_raddr + AW'(1);
        re_cyc.push_back(cyc);
        re_log.push_back(cyc);
        if (rd_left > 0) rd_left--;
      end
      if (rdata_valid_o && rdata_ready_i) begin
        chk("rd_pending", 32'(exp_rdq.size() > 0), 32'(1));
        if (exp_rdq.size() > 0) chk("rdata", 32'(rdata_o), 32'(exp_rdq.pop_front()));
        if (re_cyc.size() > 0) void'(re_cyc.pop_front());
        rd_log_cyc.push_back(cyc);
        rd_log_data.push_back(rdata_o);
      end
      if (cmd_valid_i && cmd_ready_o) begin
        if (cmd_we_i) begin
          wr_left = int'(cmd_len_i) + 1;
        end else begin
          rd_left   = int'(cmd_len_i) + 1;
          exp_raddr = cmd_addr_i;
          for (int i = 0; i <= int'(cmd_len_i); i++)
            exp_rdq.push_back(ref_mem[cmd_addr_i + AW'(i)]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_log_cyc.delete();
    we_log_addr.delete();
    re_log.delete();
    rd_log_cyc.delete();
    rd_log_data.delete();
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] len);
    int n = 0;
    while (!cmd_ready_o && n < 500) begin
      tick();
      n++;
    end
    chk("cmd_wait", 32'(cmd_ready_o), 32'(1));
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = a;
    cmd_len_i   = len;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] len, input bit gaps,
                             input bit fixed, input logic [DW-1:0] base);
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    wbeat_t        wb;
    send_cmd(1'b1, a, len);
    wa = a;
    for (int i = 0; i <= int'(len); i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      wdata_valid_i = 1'b0;
      repeat (g) tick();
      d = fixed ? base + DW'(i) : DW'($urandom);
      wdata_valid_i = 1'b1;
      wdata_i       = d;
      ref_mem[wa]   = d;
      wb.addr       = wa;
      wb.data       = d;
      exp_wq.push_back(wb);
      tick();
      wa = wa + AW'(1);
    end
    wdata_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(cmd_ready_o && !busy_o && exp_rdq.size() == 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'(1));
  endtask

  logic [AW-1:0] wrap_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
  int            gap_pat   [5] = '{1, 0, 0, 1, 1};

  initial begin
    logic [31:0]   v;
    logic [AW-1:0] idx;
    logic [AW-1:0] a;
    logic [AW-1:0] len;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    wbeat_t        wb;

    for (int i = 0; i < int'(DEPTH); i++) begin
      idx          = AW'(i);
      v            = $urandom;
      ram[idx]     <= v[DW-1:0];
      ref_mem[idx] = v[DW-1:0];
    end

    // Reset values before any clock edge.
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'(1));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_re", 32'(spad_re_o), 32'(0));
    chk("rst_we", 32'(spad_we_o), 32'(0));
    chk("rst_rvalid", 32'(rdata_valid_o), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Seed a known word, then reset in the middle of a stalled read burst.
    write_burst(10'h010, 10'd0, 1'b0, 1'b1, 8'h5A);
    rdy_mode = 0;
    send_cmd(1'b0, 10'h000, 10'd7);
    repeat (4) tick();
    chk("pre_rst_rvalid", 32'(rdata_valid_o), 32'(1));
    chk("pre_rst_busy", 32'(busy_o), 32'(1));
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_re", 32'(spad_re_o), 32'(0));
    chk("mid_rst_we", 32'(spad_we_o), 32'(0));
    chk("mid_rst_rvalid", 32'(rdata_valid_o), 32'(0));
    chk("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'(1));
    chk("mid_rst_busy", 32'(busy_o), 32'(0));
    exp_rdq.delete();
    exp_wq.delete();
    re_cyc.delete();
    rd_left = 0;
    wr_left = 0;
    tick();
    rst_ni = 1'b1;
    rdy_mode = 1;
    clear_logs();
    send_cmd(1'b0, 10'h010, 10'd0);
    wait_drain();
    chk("post_rst_count", 32'(rd_log_data.size()), 32'(1));
    if (rd_log_data.size() > 0) chk("post_rst_data", 32'(rd_log_data[0]), 32'h5A);

    // Wrapping write burst.
    clear_logs();
    write_burst(10'h3FE, 10'd3, 1'b0, 1'b1, 8'hA0);
    chk("wrap_cmd_ready", 32'(cmd_ready_o), 32'(1));
    chk("wrap_we_count", 32'(we_log_cyc.size()), 32'(4));
    for (int i = 0; i < 4 && i < we_log_cyc.size(); i++) begin
      chk("wrap_we_addr", 32'(we_log_addr[i]), 32'(wrap_addr[i]));
      chk("wrap_we_cycle", 32'(we_log_cyc[i] - we_log_cyc[0]), 32'(i));
    end

    // Streaming read-back.
    clear_logs();
    send_cmd(1'b0, 10'h3FE, 10'd3);
    wait_drain();
    chk("stream_re_count", 32'(re_log.size()), 32'(4));
    chk("stream_rd_count", 32'(rd_log_data.size()), 32'(4));
    for (int i = 0; i < 4 && i < re_log.size() && i < rd_log_data.size(); i++) begin
      chk("stream_re_cycle", 32'(re_log[i] - re_log[0]), 32'(i));
      chk("stream_rd_cycle", 32'(rd_log_cyc[i] - re_log[0]), 32'(i + 2));
      chk("stream_rd_data", 32'(rd_log_data[i]), 32'(8'hA0 + i));
    end

    // Backpressure: FIFO fills, issue stalls, then drains in order.
    rdy_mode = 0;
    clear_logs();
    send_cmd(1'b0, 10'h3FE, 10'd7);
    repeat (10) tick();
    chk("bp_re_count", 32'(re_log.size()), 32'(2));
    chk("bp_rvalid", 32'(rdata_valid_o), 32'(1));
    chk("bp_head", 32'(rdata_o), 32'hA0);
    rdy_mode = 1;
    wait_drain();
    chk("bp_re_total", 32'(re_log.size()), 32'(8));
    chk("bp_rd_total", 32'(rd_log_data.size()), 32'(8));
    for (int i = 0; i < 4 && i < rd_log_data.size(); i++)
      chk("bp_rd_data", 32'(rd_log_data[i]), 32'(8'hA0 + i));

    // Write burst with valid gaps.
    clear_logs();
    send_cmd(1'b1, 10'h100, 10'd2);
    wa = 10'h100;
    for (int i = 0; i < 5; i++) begin
      wdata_valid_i = (gap_pat[i] != 0);
      if (gap_pat[i] != 0) begin
        d           = DW'($urandom);
        wdata_i     = d;
        ref_mem[wa] = d;
        wb.addr     = wa;
        wb.data     = d;
        exp_wq.push_back(wb);
        wa = wa + AW'(1);
      end
      tick();
    end
    wdata_valid_i = 1'b0;
    chk("gap_we_count", 32'(we_log_cyc.size()), 32'(3));
    if (we_log_cyc.size() == 3) begin
      chk("gap_we_cyc1", 32'(we_log_cyc[1] - we_log_cyc[0]), 32'(3));
      chk("gap_we_cyc2", 32'(we_log_cyc[2] - we_log_cyc[0]), 32'(4));
      chk("gap_we_addr0", 32'(we_log_addr[0]), 32'h100);
      chk("gap_we_addr2", 32'(we_log_addr[2]), 32'h102);
    end
    chk("gap_cmd_ready", 32'(cmd_ready_o), 32'(1));

    // Write accepted while two read words remain buffered.
    rdy_mode = 0;
    clear_logs();
    send_cmd(1'b0, 10'h3FE, 10'd1);
    repeat (4) tick();
    chk("ovl_cmd_ready", 32'(cmd_ready_o), 32'(1));
    chk("ovl_rvalid", 32'(rdata_valid_o), 32'(1));
    write_burst(10'h200, 10'd3, 1'b0, 1'b0, 8'h00);
    rdy_mode = 1;
    wait_drain();
    chk("ovl_rd_count", 32'(rd_log_data.size()), 32'(2));
    if (rd_log_data.size() == 2) begin
      chk("ovl_rd0", 32'(rd_log_data[0]), 32'hA0);
      chk("ovl_rd1", 32'(rd_log_data[1]), 32'hA1);
    end
    send_cmd(1'b0, 10'h200, 10'd3);
    wait_drain();

    // Randomized command mix with random read backpressure.
    rdy_mode = 2;
    for (int it = 0; it < 60; it++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = AW'(DEPTH - 1 - $urandom_range(0, 3));
      len = AW'($urandom_range(0, 11));
      if ($urandom_range(0, 1) != 0) write_burst(a, len, 1'b1, 1'b0, 8'h00);
      else send_cmd(1'b0, a, len);
    end
    wait_drain();
    chk("final_rdq_empty", 32'(exp_rdq.size()), 32'(0));
    chk("final_wq_empty", 32'(exp_wq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spad_sp_port_ctrl.md
Name: spad_sp_port_ctrl

Overview:
Burst access controller that drives the port of a single-port, non-pipelined scratchpad (SPad_SP). It turns a command stream plus write-data / read-data valid/ready streams into one-access-per-cycle re/we/addr/data strobes. It sits between PE-side stream logic and each SPad instance. It owns address sequencing, port arbitration and read-latency buffering, so clients never see the 1-cycle RAM latency.

Parameters:
DATA_WIDTH, 8, width of data words (must match the attached SPad).
ADDR_WIDTH, 10, SPad address width; the burst address wraps modulo 2^ADDR_WIDTH.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_we_i  in  1  1 = write burst, 0 = read burst
cmd_addr_i  in  ADDR_WIDTH  burst start address
cmd_len_i  in  ADDR_WIDTH  beats minus one (0 = 1 beat)
wdata_valid_i  in  1  write data valid
wdata_ready_o  out  1  write data ready
wdata_i  in  DATA_WIDTH  write data
rdata_valid_o  out  1  read data valid
rdata_ready_i  in  1  read data ready
rdata_o  out  DATA_WIDTH  read data, in address order
busy_o  out  1  burst active, read in flight, or read FIFO non-empty
spad_re_o  out  1  to SPad re_i
spad_we_o  out  1  to SPad we_i
spad_addr_o  out  ADDR_WIDTH  to SPad addr_i
spad_data_o  out  DATA_WIDTH  to SPad data_i
spad_data_i  in  DATA_WIDTH  from SPad data_o; valid the cycle after spad_re_o

Behaviour:
- FSM states: IDLE, WRITE, READ. cmd_ready_o = (state==IDLE).
- Command acceptance latches cur_addr=cmd_addr_i and beats_left=cmd_len_i, then moves to WRITE or READ per cmd_we_i.
- WRITE: wdata_ready_o=1. On each wdata beat, spad_we_o=1, spad_addr_o=cur_addr and spad_data_o=wdata_i in the same cycle (combinational pass-through). cur_addr increments with wrap.
- WRITE, stalls: if wdata_valid_i=0, no strobe is issued and the address holds.
- WRITE, exit: the final beat (beats_left==0) returns the FSM to IDLE.
- READ, issue rule: spad_re_o=1 when fifo_count + inflight - pop < 2, where pop = rdata_valid_o && rdata_ready_i. cur_addr advances on each issue. The final issue returns the FSM to IDLE.
- inflight register: set on the cycle spad_re_o is asserted. On the next cycle, spad_data_i is pushed into a 2-entry read FIFO.
- Read latency: spad_re_o at cycle t → spad_data_i at t+1 → rdata_valid_o at t+2. With rdata_ready_i held high, throughput is 1 word/cycle.
- re and we are never asserted together. Both are 0 in IDLE.
- A new command may be accepted while prior read data is still in flight or buffered. Buffered data drains in order, unaffected by later writes.
- Wrap: cur_addr at 2^ADDR_WIDTH-1 increments to 0.
- FIFO full with rdata_ready_i=0: issue stalls; no data is lost or duplicated.
- Reset values, asserted asynchronously mid-operation: state=IDLE, FIFO empty, inflight=0. All strobes and valids drop to 0 immediately, busy_o=0 and cmd_ready_o=1. SPad contents are not reset; outstanding bursts are discarded.
- Strobes are combinational from registered state plus handshake inputs, so no strobe leaks during reset.

Decomposition:
- Package spad_ctrl_pkg holds the FSM state enum (IDLE/WRITE/READ) and the read FIFO depth constant (RD_FIFO_DEPTH=2).
- Sub-module spad_rd_fifo: 2-entry register FIFO with push/pop/count, reset-clear, and simultaneous push+pop supported.

Test Plan:
1. Reset: assert rst_ni=0 mid-burst → spad_re_o/spad_we_o/rdata_valid_o=0 and cmd_ready_o=1 in the same cycle. After release, a 1-beat read of a previously written address returns the old data.
2. Wrapping write: addr=0x3FE, len=3, data A0..A3 with wdata_valid_i held high → we on 4 consecutive cycles at 0x3FE, 0x3FF, 0x000, 0x001. cmd_ready_o is high the cycle after the 4th beat.
3. Read-back streaming: read addr=0x3FE, len=3, rdata_ready_i=1 → re on 4 consecutive cycles; rdata_o=A0,A1,A2,A3 on 4 consecutive cycles, the first 2 cycles after the first re.
4. Backpressure: read len=7 with rdata_ready_i=0 → exactly 2 re pulses, then stall with rdata_valid_o=1 holding the first word. Release ready → all 8 words delivered in order, with no duplicates.
5. Write gaps: wdata_valid_i toggling 1,0,0,1,1 on a 3-beat burst → we only on the valid cycles; addresses are consecutive with no skips.
6. Overlap: a write command is accepted while 2 read words are still buffered → buffered words delivered unchanged; the new writes land correctly (checked by a subsequent read).
